// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS control unit.
// The control unit is the slave; the datapath side uses the master modport.
interface multicycle_control_if #(
   parameter int ALU_OP_WIDTH = 3,
   parameter int CNT_WIDTH    = 32
);
   logic [5:0]              opcode_i;
   logic                    mem_ready_i;
   logic                    pc_write_o;
   logic                    pc_write_cond_eq_o;
   logic                    pc_write_cond_ne_o;
   logic                    i_or_d_o;
   logic                    mem_read_o;
   logic                    mem_write_o;
   logic                    ir_write_o;
   logic                    reg_dst_o;
   logic                    mem_to_reg_o;
   logic                    reg_write_o;
   logic                    alu_src_a_o;
   logic [1:0]              alu_src_b_o;
   logic [1:0]              pc_source_o;
   logic [ALU_OP_WIDTH-1:0] alu_op_o;
   logic [3:0]              state_o;
   logic                    illegal_o;
   logic [CNT_WIDTH-1:0]    instr_count_o;

   modport slave (
      input  opcode_i, mem_ready_i,
      output pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
             mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
             reg_write_o, alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o,
             state_o, illegal_o, instr_count_o
   );

   modport master (
      output opcode_i, mem_ready_i,
      input  pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o, i_or_d_o,
             mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
             reg_write_o, alu_src_a_o, alu_src_b_o, pc_source_o, alu_op_o,
             state_o, illegal_o, instr_count_o
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: fetch, decode, execute,
// memory and write-back, with optional memory wait, illegal trap and retire count.
module multicycle_control #(
   parameter int ALU_OP_WIDTH = 3,
   parameter int MEM_WAIT_EN  = 0,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   multicycle_control_if.slave   bus
);
   typedef enum logic [3:0] {
      S_FETCH    = 4'h0,
      S_DECODE   = 4'h1,
      S_MEM_ADDR = 4'h2,
      S_MEM_RD   = 4'h3,
      S_MEM_WB   = 4'h4,
      S_MEM_WR   = 4'h5,
      S_R_EXEC   = 4'h6,
      S_R_WB     = 4'h7,
      S_BRANCH   = 4'h8,
      S_JUMP     = 4'h9,
      S_I_EXEC   = 4'hA,
      S_I_WB     = 4'hB,
      S_ILLEGAL  = 4'hF
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(3'b100);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(3'b011);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = ALU_OP_WIDTH'(3'b010);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI = ALU_OP_WIDTH'(3'b001);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_R   = ALU_OP_WIDTH'(3'b111);

   state_t                  r_state;
   state_t                  w_next;
   logic [5:0]              r_op;
   logic [CNT_WIDTH-1:0]    r_count;

   logic                    w_ready;
   logic                    w_retire;
   logic                    w_pc_write, w_cond_eq, w_cond_ne, w_i_or_d;
   logic                    w_mem_read, w_mem_write, w_ir_write;
   logic                    w_reg_dst, w_mem_to_reg, w_reg_write;
   logic                    w_alu_src_a, w_illegal;
   logic [1:0]              w_alu_src_b, w_pc_source;
   logic [ALU_OP_WIDTH-1:0] w_alu_op;

   assign w_ready = (MEM_WAIT_EN != 0) ? bus.mem_ready_i : 1'b1;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= S_FETCH;
         r_op    <= 6'h00;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE)
            r_op <= bus.opcode_i;
         if (w_retire)
            r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      w_next       = S_FETCH;
      w_pc_write   = 1'b0;
      w_cond_eq    = 1'b0;
      w_cond_ne    = 1'b0;
      w_i_or_d     = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_pc_source  = 2'b00;
      w_alu_op     = '0;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            w_alu_op    = ALU_ADD;
            w_ir_write  = w_ready;
            w_pc_write  = w_ready;
            w_next      = w_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            w_alu_op    = ALU_ADD;
            case (bus.opcode_i)
               OP_RTYPE:               w_next = S_R_EXEC;
               OP_ADDI, OP_ORI, OP_LUI: w_next = S_I_EXEC;
               OP_LW, OP_SW:           w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE:         w_next = S_BRANCH;
               OP_J:                   w_next = S_JUMP;
               default:                w_next = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_alu_op    = ALU_ADD;
            w_next      = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 1'b1;
            w_next     = w_ready ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         // The write strobe is held for the whole wait so the memory sees a stable request.
         S_MEM_WR: begin
            w_mem_write = 1'b1;
            w_i_or_d    = 1'b1;
            w_next      = w_ready ? S_FETCH : S_MEM_WR;
         end
         S_R_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_R;
            w_next      = S_R_WB;
         end
         S_R_WB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            case (r_op)
               OP_ORI:  w_alu_op = ALU_OR;
               OP_LUI:  w_alu_op = ALU_LUI;
               default: w_alu_op = ALU_ADD;
            endcase
            w_next = S_I_WB;
         end
         S_I_WB: begin
            w_reg_write = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_SUB;
            w_pc_source = 2'b01;
            w_cond_eq   = (r_op == OP_BEQ);
            w_cond_ne   = (r_op == OP_BNE);
         end
         S_JUMP: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b10;
         end
         S_ILLEGAL: begin
            w_illegal = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Only real completions retire; ILLEGAL and FETCH returning to itself do not.
   assign w_retire = (w_next == S_FETCH) &&
                     (r_state inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP});

   assign bus.pc_write_o         = w_pc_write  & ~reset_i;
   assign bus.pc_write_cond_eq_o = w_cond_eq   & ~reset_i;
   assign bus.pc_write_cond_ne_o = w_cond_ne   & ~reset_i;
   assign bus.ir_write_o         = w_ir_write  & ~reset_i;
   assign bus.mem_write_o        = w_mem_write & ~reset_i;
   assign bus.reg_write_o        = w_reg_write & ~reset_i;
   assign bus.i_or_d_o           = w_i_or_d;
   assign bus.mem_read_o         = w_mem_read;
   assign bus.reg_dst_o          = w_reg_dst;
   assign bus.mem_to_reg_o       = w_mem_to_reg;
   assign bus.alu_src_a_o        = w_alu_src_a;
   assign bus.alu_src_b_o        = w_alu_src_b;
   assign bus.pc_source_o        = w_pc_source;
   assign bus.alu_op_o           = w_alu_op;
   assign bus.illegal_o          = w_illegal;
   assign bus.state_o            = r_state;
   assign bus.instr_count_o      = r_count;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a wait-enabled 4-bit-counter instance and a
// no-wait 32-bit-counter instance, checked against a per-cycle expectation queue.
module tb_multicycle_control;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cnt1;
   int   cnt2;

   typedef struct {
      logic [3:0]  st;
      logic [18:0] ctrl;
      logic        rdy;
   } exp_t;

   exp_t q[$];

   multicycle_control_if #(.ALU_OP_WIDTH(3), .CNT_WIDTH(4))  bus1 ();
   multicycle_control_if #(.ALU_OP_WIDTH(3), .CNT_WIDTH(32)) bus2 ();

   multicycle_control #(.ALU_OP_WIDTH(3), .MEM_WAIT_EN(1), .CNT_WIDTH(4)) dut1 (
      .clk_i(clk), .reset_i(rst), .bus(bus1));
   multicycle_control #(.ALU_OP_WIDTH(3), .MEM_WAIT_EN(0), .CNT_WIDTH(32)) dut2 (
      .clk_i(clk), .reset_i(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control word from the state table:
   // {pcw, ceq, cne, iord, mrd, mwr, irw, rdst, m2r, rwr, srca, srcb[2], psrc[2], aluop[3], ill}
   function automatic logic [18:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                            input logic rdy);
      logic pcw, ceq, cne, iod, mr, mw, irw, rd, m2r, rw, sa, ill;
      logic [1:0] sb, ps;
      logic [2:0] ao;
      {pcw, ceq, cne, iod, mr, mw, irw, rd, m2r, rw, sa, ill} = '0;
      sb = 2'b00; ps = 2'b00; ao = 3'b000;
      case (st)
         4'h0: begin mr = 1; sb = 2'b01; ao = 3'b100; irw = rdy; pcw = rdy; end
         4'h1: begin sb = 2'b11; ao = 3'b100; end
         4'h2: begin sa = 1; sb = 2'b10; ao = 3'b100; end
         4'h3: begin mr = 1; iod = 1; end
         4'h4: begin rw = 1; m2r = 1; end
         4'h5: begin mw = 1; iod = 1; end
         4'h6: begin sa = 1; ao = 3'b111; end
         4'h7: begin rw = 1; rd = 1; end
         4'h8: begin sa = 1; ao = 3'b011; ps = 2'b01;
                     ceq = (op == 6'h04); cne = (op == 6'h05); end
         4'h9: begin pcw = 1; ps = 2'b10; end
         4'hA: begin sa = 1; sb = 2'b10;
                     ao = (op == 6'h0D) ? 3'b010 : (op == 6'h0F) ? 3'b001 : 3'b100; end
         4'hB: begin rw = 1; end
         4'hF: begin ill = 1; end
         default: ;
      endcase
      return {pcw, ceq, cne, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ps, ao, ill};
   endfunction

   function automatic logic [18:0] ctrl1();
      return {bus1.pc_write_o, bus1.pc_write_cond_eq_o, bus1.pc_write_cond_ne_o,
              bus1.i_or_d_o, bus1.mem_read_o, bus1.mem_write_o, bus1.ir_write_o,
              bus1.reg_dst_o, bus1.mem_to_reg_o, bus1.reg_write_o, bus1.alu_src_a_o,
              bus1.alu_src_b_o, bus1.pc_source_o, bus1.alu_op_o, bus1.illegal_o};
   endfunction

   function automatic logic [18:0] ctrl2();
      return {bus2.pc_write_o, bus2.pc_write_cond_eq_o, bus2.pc_write_cond_ne_o,
              bus2.i_or_d_o, bus2.mem_read_o, bus2.mem_write_o, bus2.ir_write_o,
              bus2.reg_dst_o, bus2.mem_to_reg_o, bus2.reg_write_o, bus2.alu_src_a_o,
              bus2.alu_src_b_o, bus2.pc_source_o, bus2.alu_op_o, bus2.illegal_o};
   endfunction

   task automatic add_exp(input logic [3:0] st, input logic [5:0] op, input logic rdy);
      exp_t e;
      e.st   = st;
      e.rdy  = rdy;
      e.ctrl = exp_ctrl(st, op, rdy);
      q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst  = 1'b0;
      cnt1 = 0;
      cnt2 = 0;
   endtask

   // Queue the full expected visit sequence for one instruction on dut1, then play it.
   task automatic run_instr(input string name, input logic [5:0] op,
                            input int fwait, input int mwait);
      exp_t e;
      logic retire;
      int   cyc;
      retire = 1'b1;
      bus1.opcode_i = op;
      for (int i = 0; i < fwait; i++) add_exp(4'h0, op, 1'b0);
      add_exp(4'h0, op, 1'b1);
      add_exp(4'h1, op, 1'($urandom_range(0, 1)));
      case (op)
         6'h00: begin add_exp(4'h6, op, 1'b1); add_exp(4'h7, op, 1'($urandom_range(0, 1))); end
         6'h08, 6'h0D, 6'h0F: begin add_exp(4'hA, op, 1'b0); add_exp(4'hB, op, 1'b1); end
         6'h23: begin
            add_exp(4'h2, op, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mwait; i++) add_exp(4'h3, op, 1'b0);
            add_exp(4'h3, op, 1'b1);
            add_exp(4'h4, op, 1'($urandom_range(0, 1)));
         end
         6'h2B: begin
            add_exp(4'h2, op, 1'($urandom_range(0, 1)));
            for (int i = 0; i < mwait; i++) add_exp(4'h5, op, 1'b0);
            add_exp(4'h5, op, 1'b1);
         end
         6'h04, 6'h05: add_exp(4'h8, op, 1'($urandom_range(0, 1)));
         6'h02:        add_exp(4'h9, op, 1'($urandom_range(0, 1)));
         default: begin add_exp(4'hF, op, 1'($urandom_range(0, 1))); retire = 1'b0; end
      endcase
      cyc = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         bus1.mem_ready_i = e.rdy;
         #1;
         checks++;
         if (bus1.state_o !== e.st || ctrl1() !== e.ctrl) begin
            failures++;
            $display("FAIL %s cyc%0d: state=%h ctrl=%b, expected state=%h ctrl=%b",
                     name, cyc, bus1.state_o, ctrl1(), e.st, e.ctrl);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (retire) cnt1 = (cnt1 + 1) % 16;
      checks++;
      if (bus1.state_o !== 4'h0 || bus1.instr_count_o !== 4'(cnt1)) begin
         failures++;
         $display("FAIL %s end: state=%h count=%0d, expected state=0 count=%0d",
                  name, bus1.state_o, bus1.instr_count_o, cnt1);
      end
   endtask

   task automatic test_reset();
      bus1.opcode_i = 6'h00; bus1.mem_ready_i = 1'b1;
      bus2.opcode_i = 6'h00; bus2.mem_ready_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus1.state_o !== 4'h0 || bus1.instr_count_o !== 4'd0) begin
         failures++;
         $display("FAIL reset_state: state=%h count=%0d, expected 0/0",
                  bus1.state_o, bus1.instr_count_o);
      end
      checks++;
      if (bus1.pc_write_o !== 1'b0 || bus1.ir_write_o !== 1'b0 || bus1.mem_read_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_strobes: pcw=%b irw=%b mrd=%b, expected 0 0 1",
                  bus1.pc_write_o, bus1.ir_write_o, bus1.mem_read_o);
      end
      @(posedge clk); #1;
      rst = 1'b0; cnt1 = 0; cnt2 = 0;
      #1;
      checks++;
      if (ctrl1() !== exp_ctrl(4'h0, 6'h00, 1'b1)) begin
         failures++;
         $display("FAIL reset_release: ctrl=%b, expected %b", ctrl1(), exp_ctrl(4'h0, 6'h00, 1'b1));
      end
   endtask

   task automatic test_rtype();
      run_instr("rtype", 6'h00, 0, 0);
   endtask

   task automatic test_lw_wait();
      run_instr("lw_wait2", 6'h23, 0, 2);
      run_instr("lw_nowait", 6'h23, 0, 0);
   endtask

   task automatic test_store_and_imm();
      run_instr("sw_wait1", 6'h2B, 0, 1);
      run_instr("addi", 6'h08, 0, 0);
      run_instr("ori_fwait2", 6'h0D, 2, 0);
      run_instr("lui", 6'h0F, 0, 0);
   endtask

   task automatic test_branch();
      run_instr("beq", 6'h04, 0, 0);
      run_instr("bne", 6'h05, 0, 0);
   endtask

   task automatic test_illegal();
      run_instr("illegal_3f", 6'h3F, 0, 0);
      run_instr("illegal_01", 6'h01, 1, 0);
   endtask

   task automatic test_reset_mid();
      bus1.opcode_i = 6'h2B;
      bus1.mem_ready_i = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      bus1.mem_ready_i = 1'b0;
      #1;
      checks++;
      if (bus1.state_o !== 4'h5 || bus1.mem_write_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: state=%h mwr=%b, expected 5/1", bus1.state_o, bus1.mem_write_o);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus1.mem_write_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_mwr: mwr=%b, expected 0", bus1.mem_write_o);
      end
      @(posedge clk); #1;
      checks++;
      if (bus1.state_o !== 4'h0 || bus1.instr_count_o !== 4'd0) begin
         failures++;
         $display("FAIL mid_after: state=%h count=%0d, expected 0/0",
                  bus1.state_o, bus1.instr_count_o);
      end
      rst = 1'b0; cnt1 = 0; cnt2 = 0;
   endtask

   task automatic test_nowait();
      logic [3:0] seq [5];
      seq[0] = 4'h0; seq[1] = 4'h1; seq[2] = 4'h2; seq[3] = 4'h3; seq[4] = 4'h4;
      bus2.opcode_i = 6'h23;
      bus2.mem_ready_i = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (bus2.state_o !== seq[i] || ctrl2() !== exp_ctrl(seq[i], 6'h23, 1'b1)) begin
            failures++;
            $display("FAIL nowait_lw cyc%0d: state=%h ctrl=%b, expected state=%h ctrl=%b",
                     i, bus2.state_o, ctrl2(), seq[i], exp_ctrl(seq[i], 6'h23, 1'b1));
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus2.state_o !== 4'h0 || bus2.instr_count_o !== 32'd1) begin
         failures++;
         $display("FAIL nowait_end: state=%h count=%0d, expected 0/1",
                  bus2.state_o, bus2.instr_count_o);
      end
   endtask

   task automatic test_jump_wrap();
      do_reset();
      for (int i = 0; i < 16; i++) run_instr($sformatf("jump%0d", i), 6'h02, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; failures = 0; cnt1 = 0; cnt2 = 0; rst = 1'b1;
      bus1.opcode_i = 6'h00; bus1.mem_ready_i = 1'b1;
      bus2.opcode_i = 6'h00; bus2.mem_ready_i = 1'b0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_store_and_imm();
      test_branch();
      test_illegal();
      test_reset_mid();
      test_nowait();
      test_jump_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back, one datapath step per clock. It replaces the single-cycle opcode decoder. It adds a parametrised ALU-op width, an optional memory wait handshake, illegal-opcode trapping and a retired-instruction counter. It sits beside the register file and ALU, drives every datapath mux and strobe, and reads the opcode from the instruction register.

## Interface
- ALU_OP_WIDTH, 3: width of alu_op_o, must be ≥3; the codes below are zero-extended.
- MEM_WAIT_EN, 0: 1 = memory states hold until mem_ready_i; 0 = mem_ready_i ignored, one cycle per access.
- CNT_WIDTH, 32: width of instr_count_o.
- clk_i  in  1  clock; every register updates on the rising edge.
- reset_i  in  1  one clock; reset is synchronous and active-high.
- opcode_i  in  6  instr[31:26] from the instruction register.
- mem_ready_i  in  1  memory access completes this cycle.
- pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o  out  1 each  PC load enables (unconditional / if zero / if not zero).
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o, mem_write_o, ir_write_o  out  1 each  memory and IR strobes.
- reg_dst_o, mem_to_reg_o, reg_write_o  out  1 each  register-file controls.
- alu_src_a_o  out  1  0 = PC, 1 = rs.
- alu_src_b_o  out  2  00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- pc_source_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op_o  out  ALU_OP_WIDTH  codes: 100 add, 011 sub, 010 or, 001 lui, 111 R-type (funct).
- state_o  out  4  current state, for debug.
- illegal_o  out  1  high for the one ILLEGAL cycle.
- instr_count_o  out  CNT_WIDTH  count of retired instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC A, I_WB B, ILLEGAL F. Codes C–E go to FETCH.
- Outputs are a function of the state and op_r only. op_r is a 6-bit opcode register loaded in DECODE. Any output not listed for a state is 0.
- FETCH: mem_read, alu_src_b=01, alu_op add, pc_source=00.
  - Also ir_write and pc_write, gated by ready. ready = mem_ready_i if MEM_WAIT_EN, else 1.
  - Moves to DECODE when ready; otherwise stays in FETCH.
- DECODE: alu_src_b=11, alu_op add. Dispatch on opcode_i:
  - 0x00 → R_EXEC.
  - 0x08 ADDI, 0x0D ORI, 0x0F LUI → I_EXEC.
  - 0x23 LW, 0x2B SW → MEM_ADDR.
  - 0x04 BEQ, 0x05 BNE → BRANCH.
  - 0x02 J → JUMP.
  - Any other opcode → ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op add. Next state MEM_RD if op_r=0x23, else MEM_WR.
- MEM_RD: mem_read, i_or_d=1. Moves to MEM_WB when ready.
- MEM_WB: reg_write, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WR: mem_write, i_or_d=1. Moves to FETCH when ready.
  - mem_write stays high on every wait cycle.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op 111. Next state R_WB.
- R_WB: reg_write, reg_dst=1. Next state FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op is add for 0x08, or for 0x0D, lui for 0x0F. Next state I_WB.
- I_WB: reg_write, reg_dst=0, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op sub, pc_source=01.
  - pc_write_cond_eq high if op_r=0x04; pc_write_cond_ne high if op_r=0x05.
  - Next state FETCH.
- JUMP: pc_write, pc_source=10. Next state FETCH.
- ILLEGAL: illegal_o=1, all strobes 0. Next state FETCH. Not counted as retired.
- instr_count_o increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP.
  - Wraps from 2^CNT_WIDTH−1 to 0.
  - A BRANCH counts as retired whether or not it is taken.

## Timing
- Reset: any state goes to FETCH on the next edge; op_r=0 and instr_count_o=0.
  - While reset_i is high, pc_write, pc_write_cond_*, ir_write, mem_write and reg_write are forced to 0, whatever the state.
  - After reset, outputs take the FETCH values.
- Reset in the middle of an instruction abandons it with no count and no further strobes.
- Cycles per instruction with zero wait:
  - LW 5.
  - R-type, ADDI, ORI, LUI and SW 4.
  - BEQ, BNE and J 3.
  - Illegal opcode 3.
- Each cycle with ready low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobes last exactly one cycle per state visit, except during memory waits.
- On the completing cycle of FETCH, ir_write and pc_write are both high.

## Test plan
- Reset, then opcode 0x00 with mem_ready_i=1: state sequence 0,1,6,7,0. reg_write and reg_dst are high only in state 7. instr_count_o=1 after 4 cycles.
- LW (0x23), MEM_WAIT_EN=1, mem_ready_i low for 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,4,0, i.e. 7 cycles. mem_to_reg=1 in state 4.
- BEQ then BNE: state 8 shows pc_write_cond_eq=1, pc_write_cond_ne=0, then the reverse. alu_op=011 and pc_source=01 in both.
- Opcode 0x3F: sequence 0,1,F,0. illegal_o is high for 1 cycle. instr_count_o is unchanged. No strobes fire.
- reset_i asserted in state 5 while mem_write=1: mem_write reads 0 in that cycle, state=0 on the next edge, instr_count_o=0.
- CNT_WIDTH=4, 16 J instructions (0x02): instr_count_o wraps from 15 to 0. Each J takes 3 cycles with pc_source=10.
